// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } pc_state_t;

  localparam int   INSTR_BYTES = 4;
  localparam logic HALT_EXT    = 1'b0;
  localparam logic HALT_INT    = 1'b1;

endpackage

// File: rtl/pc_next_select.sv
// Combinational next-pc / next-state selection for the fetch sequencer.
module pc_next_select
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  pc_state_t         state,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall_req,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt,
  input  logic              haltext,
  input  logic              resume,
  output logic [ADDR_W-1:0] next_pc,
  output pc_state_t         next_state,
  output logic              retire_en,
  output logic              misalign
);

  logic [ADDR_W-1:0] seq_pc;

  assign seq_pc = pc + ADDR_W'(INSTR_BYTES);

  // An external halt pre-empts even a stalled instruction; everything else waits on the stall.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    retire_en  = 1'b0;
    misalign   = 1'b0;
    unique case (state)
      RUN: begin
        if (haltext && !halt) begin
          next_state = HALTED;
        end else if (stall_req) begin
          next_state = RUN;
        end else if (halt) begin
          next_state = HALTED;
          next_pc    = seq_pc;
          retire_en  = 1'b1;
        end else if (jump) begin
          if (jump_target[1:0] != 2'b00) begin
            next_state = FAULT;
            misalign   = 1'b1;
          end else begin
            next_pc   = jump_target;
            retire_en = 1'b1;
          end
        end else if (branch_taken) begin
          if (branch_target[1:0] != 2'b00) begin
            next_state = FAULT;
            misalign   = 1'b1;
          end else begin
            next_pc   = branch_target;
            retire_en = 1'b1;
          end
        end else begin
          next_pc   = seq_pc;
          retire_en = 1'b1;
        end
      end
      HALTED: begin
        if (resume && !haltext) next_state = RUN;
      end
      default: begin
        next_state = FAULT;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner: state, pc, halt cause, sticky fault and retired-instruction counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_req,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt,
  input  logic              haltext,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic              halted,
  output logic              halt_cause,
  output logic              fault,
  output logic [CNT_W-1:0]  retired_count
);

  pc_state_t         state;
  pc_state_t         next_state;
  logic [ADDR_W-1:0] next_pc;
  logic              retire_en;
  logic              misalign;

  pc_next_select #(.ADDR_W(ADDR_W)) u_sel (
    .state         (state),
    .pc            (pc),
    .stall_req     (stall_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt          (halt),
    .haltext       (haltext),
    .resume        (resume),
    .next_pc       (next_pc),
    .next_state    (next_state),
    .retire_en     (retire_en),
    .misalign      (misalign)
  );

  // Cause is captured only on entry to HALTED; an internal halt always wins that entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      pc            <= RESET_ADDR;
      halt_cause    <= HALT_EXT;
      fault         <= 1'b0;
      retired_count <= '0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      fault <= fault | misalign;
      if (retire_en) retired_count <= retired_count + CNT_W'(1);
      if (state == RUN && next_state == HALTED) halt_cause <= halt ? HALT_INT : HALT_EXT;
    end
  end

  assign fetch_valid = (state == RUN);
  assign halted      = (state == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expectations, a monitor pops and compares.
module tb_pc_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        hl;
    logic        hc;
    logic        ft;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_req = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        halt = 1'b0;
  logic        haltext = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        halted;
  logic        halt_cause;
  logic        fault;
  logic [31:0] retired_count;

  exp_t expq[$];
  int   compared = 0;
  int   mismatched = 0;
  bit   stim_done = 1'b0;

  pc_sequencer #(.ADDR_W(32), .RESET_ADDR(32'h100), .CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_req     (stall_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt          (halt),
    .haltext       (haltext),
    .resume        (resume),
    .pc            (pc),
    .fetch_valid   (fetch_valid),
    .halted        (halted),
    .halt_cause    (halt_cause),
    .fault         (fault),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic checkField(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", nm, fld, act, expv);
    end
  endtask

  // halt_cause only carries meaning while halted, so it is compared only then.
  task automatic checkOutput(input exp_t e);
    checkField(e.name, "pc", pc, e.pc);
    checkField(e.name, "fetch_valid", 32'(fetch_valid), 32'(e.fv));
    checkField(e.name, "halted", 32'(halted), 32'(e.hl));
    checkField(e.name, "fault", 32'(fault), 32'(e.ft));
    checkField(e.name, "retired_count", retired_count, e.cnt);
    if (e.hl) checkField(e.name, "halt_cause", 32'(halt_cause), 32'(e.hc));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) checkOutput(expq.pop_front());
    end
  end

  // ctl bits: {reset, stall_req, branch_taken, jump, halt, haltext, resume}
  task automatic applyStimulus(input string nm, input logic [6:0] ctl, input logic [31:0] bt, input logic [31:0] jt,
                               input logic [31:0] e_pc, input logic e_fv, input logic e_hl, input logic e_hc,
                               input logic e_ft, input logic [31:0] e_cnt);
    exp_t e;
    @(negedge clk);
    {reset, stall_req, branch_taken, jump, halt, haltext, resume} = ctl;
    branch_target = bt;
    jump_target   = jt;
    e.pc = e_pc; e.fv = e_fv; e.hl = e_hl; e.hc = e_hc; e.ft = e_ft; e.cnt = e_cnt; e.name = nm;
    expq.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    //              name            rst,stl,br,jp,hl,hx,rs  br_tgt        jmp_tgt       pc            fv hl hc ft cnt
    applyStimulus("reset",         7'b1000000, 32'h0,        32'h0,        32'h100,      1, 0, 0, 0, 0);
    applyStimulus("seq1",          7'b0000000, 32'h0,        32'h0,        32'h104,      1, 0, 0, 0, 1);
    applyStimulus("seq2",          7'b0000000, 32'h0,        32'h0,        32'h108,      1, 0, 0, 0, 2);
    applyStimulus("seq3",          7'b0000000, 32'h0,        32'h0,        32'h10C,      1, 0, 0, 0, 3);
    applyStimulus("jump_to_20",    7'b0001000, 32'h0,        32'h20,       32'h20,       1, 0, 0, 0, 4);
    applyStimulus("jump_over_br",  7'b0011000, 32'h40,       32'h80,       32'h80,       1, 0, 0, 0, 5);
    applyStimulus("jump_to_30",    7'b0001000, 32'h0,        32'h30,       32'h30,       1, 0, 0, 0, 6);
    applyStimulus("halt_int_win",  7'b0000110, 32'h0,        32'h0,        32'h34,       0, 1, 1, 0, 7);
    applyStimulus("resume_blocked",7'b0000011, 32'h0,        32'h0,        32'h34,       0, 1, 1, 0, 7);
    applyStimulus("halted_ignore", 7'b0001000, 32'h0,        32'h200,      32'h34,       0, 1, 1, 0, 7);
    applyStimulus("resume_ok",     7'b0000001, 32'h0,        32'h0,        32'h34,       1, 0, 0, 0, 7);
    applyStimulus("after_resume",  7'b0000000, 32'h0,        32'h0,        32'h38,       1, 0, 0, 0, 8);
    applyStimulus("branch_to_50",  7'b0010000, 32'h50,       32'h0,        32'h50,       1, 0, 0, 0, 9);
    applyStimulus("stall1",        7'b0110000, 32'h90,       32'h0,        32'h50,       1, 0, 0, 0, 9);
    applyStimulus("stall2",        7'b0110000, 32'h90,       32'h0,        32'h50,       1, 0, 0, 0, 9);
    applyStimulus("stall_haltext", 7'b0110010, 32'h90,       32'h0,        32'h50,       0, 1, 0, 0, 9);
    applyStimulus("resume_ext",    7'b0000001, 32'h0,        32'h0,        32'h50,       1, 0, 0, 0, 9);
    applyStimulus("seq_54",        7'b0000000, 32'h0,        32'h0,        32'h54,       1, 0, 0, 0, 10);
    applyStimulus("jump_misalign", 7'b0001000, 32'h0,        32'h82,       32'h54,       0, 0, 0, 1, 10);
    applyStimulus("fault_resume",  7'b0000001, 32'h0,        32'h0,        32'h54,       0, 0, 0, 1, 10);
    applyStimulus("fault_branch",  7'b0010000, 32'h60,       32'h0,        32'h54,       0, 0, 0, 1, 10);
    applyStimulus("fault_reset",   7'b1000000, 32'h0,        32'h0,        32'h100,      1, 0, 0, 0, 0);
    applyStimulus("br_misalign",   7'b0010000, 32'h41,       32'h0,        32'h100,      0, 0, 0, 1, 0);
    applyStimulus("reset2",        7'b1000000, 32'h0,        32'h0,        32'h100,      1, 0, 0, 0, 0);
    applyStimulus("jump_top",      7'b0001000, 32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0, 0, 0, 1);
    applyStimulus("pc_wrap",       7'b0000000, 32'h0,        32'h0,        32'h0,        1, 0, 0, 0, 2);
    applyStimulus("haltext_only",  7'b0000010, 32'h0,        32'h0,        32'h0,        0, 1, 0, 0, 2);
    applyStimulus("reset_halted",  7'b1000000, 32'h0,        32'h0,        32'h100,      1, 0, 0, 0, 0);
    applyStimulus("seq_104",       7'b0000000, 32'h0,        32'h0,        32'h104,      1, 0, 0, 0, 1);
    applyStimulus("stall_over_hx", 7'b0100110, 32'h0,        32'h0,        32'h104,      1, 0, 0, 0, 1);
    applyStimulus("halt_int",      7'b0000100, 32'h0,        32'h0,        32'h108,      0, 1, 1, 0, 2);
    applyStimulus("final_reset",   7'b1000000, 32'h0,        32'h0,        32'h100,      1, 0, 0, 0, 0);
    @(negedge clk);
    {reset, stall_req, branch_taken, jump, halt, haltext, resume} = 7'b0;
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion before 100000");
    $fatal(1, "[TB] timeout");
  end

endmodule
